// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
//   LINE_BYTES     : bytes per cache line (one instruction-memory block)
//   WORDS_PER_LINE : 32-bit instruction words per line
//   OFFSET_W       : byte-offset bits inside a line
//   icache_state_e : fill FSM states
package icache_pkg;

  localparam int unsigned LINE_BYTES     = 16;
  localparam int unsigned WORDS_PER_LINE = 4;
  localparam int unsigned OFFSET_W       = 4;
  localparam int unsigned LINE_W         = LINE_BYTES * 8;

  typedef enum logic [1:0] {
    IDLE,
    MEM_READ,
    UPDATE
  } icache_state_e;

endpackage

// File: rtl/icache_word_select.sv
// Picks one 32-bit instruction word out of a 128-bit cache line.
//   line_data : full cache line, word n in bits [32n+31:32n]
//   word_sel  : word offset within the line (address bits [3:2])
//   word_data : selected instruction word
module icache_word_select
  import icache_pkg::*;
(
  input  logic [LINE_W-1:0] line_data,
  input  logic [1:0]        word_sel,
  output logic [31:0]       word_data
);

  always_comb begin
    word_data = line_data[31:0];
    unique case (word_sel)
      2'd0: word_data = line_data[31:0];
      2'd1: word_data = line_data[63:32];
      2'd2: word_data = line_data[95:64];
      2'd3: word_data = line_data[127:96];
      default: word_data = line_data[31:0];
    endcase
  end

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache between CPU fetch and a 128-bit
// block instruction memory. Hits return data in the request cycle; misses stall
// the CPU while the whole line is fetched, then complete as a hit.
//   clock, reset  : single clock, synchronous active-high reset
//   cpu_read      : fetch request (held with stable address while stalled)
//   cpu_address   : instruction byte address, bits [1:0] ignored
//   cpu_readdata  : fetched instruction, valid when cpu_read && !cpu_busywait
//   cpu_busywait  : stall to the CPU
//   mem_read      : block read request to instruction memory
//   mem_address   : block address (byte address [31:4])
//   mem_readdata  : returned block, byte n in bits [8n+7:8n]
//   mem_busywait  : memory busy, falls when mem_readdata is valid
module instruction_cache
  import icache_pkg::*;
#(
  parameter int unsigned NUM_LINES = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_read,
  input  logic [31:0]       cpu_address,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_busywait,
  output logic              mem_read,
  output logic [27:0]       mem_address,
  input  logic [LINE_W-1:0] mem_readdata,
  input  logic              mem_busywait
);

  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = 32 - OFFSET_W - IDX_W;

  // Storage arrays
  logic [TAG_W-1:0]  tag_q  [NUM_LINES];
  logic [LINE_W-1:0] data_q [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;

  // Request address split
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_index;
  logic [1:0]       req_offset;

  assign req_tag    = cpu_address[31:OFFSET_W+IDX_W];
  assign req_index  = cpu_address[OFFSET_W+IDX_W-1:OFFSET_W];
  assign req_offset = cpu_address[3:2];

  // Byte-within-word bits carry no information for word fetches.
  logic unused_byte_bits;
  assign unused_byte_bits = ^cpu_address[1:0];

  // FSM and fill bookkeeping
  icache_state_e    state_q, state_d;
  logic             seen_busy_q, seen_busy_d;
  logic [TAG_W-1:0] miss_tag_q, miss_tag_d;
  logic [IDX_W-1:0] miss_index_q, miss_index_d;
  logic [31:0]      readdata_q;

  logic        hit;
  logic        hit_ok;
  logic        fill_en;
  logic [31:0] hit_word;

  assign hit = valid_q[req_index] && (tag_q[req_index] == req_tag);

  icache_word_select u_word_select (
    .line_data (data_q[req_index]),
    .word_sel  (req_offset),
    .word_data (hit_word)
  );

  // Only an IDLE hit is a completed fetch; in other states the line may be
  // about to be replaced.
  assign hit_ok  = cpu_read && (state_q == IDLE) && hit;
  assign fill_en = (state_q == UPDATE);

  always_comb begin
    state_d      = state_q;
    seen_busy_d  = seen_busy_q;
    miss_tag_d   = miss_tag_q;
    miss_index_d = miss_index_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_read && !hit) begin
          state_d      = MEM_READ;
          miss_tag_d   = req_tag;
          miss_index_d = req_index;
          // Memory already busy on the entry edge still counts as a handshake.
          seen_busy_d  = mem_busywait;
        end
      end
      MEM_READ: begin
        seen_busy_d = seen_busy_q | mem_busywait;
        if (seen_busy_q && !mem_busywait) begin
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        state_d     = IDLE;
        seen_busy_d = 1'b0;
      end
      default: begin
        state_d     = IDLE;
        seen_busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      seen_busy_q  <= 1'b0;
      miss_tag_q   <= '0;
      miss_index_q <= '0;
      valid_q      <= '0;
      readdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      seen_busy_q  <= seen_busy_d;
      miss_tag_q   <= miss_tag_d;
      miss_index_q <= miss_index_d;
      if (fill_en) begin
        valid_q[miss_index_q] <= 1'b1;
      end
      if (hit_ok) begin
        readdata_q <= hit_word;
      end
    end
  end

  // Tag and data need no reset: the valid bits qualify them.
  always_ff @(posedge clock) begin
    if (!reset && fill_en) begin
      tag_q[miss_index_q]  <= miss_tag_q;
      data_q[miss_index_q] <= mem_readdata;
    end
  end

  assign mem_read     = (state_q == MEM_READ);
  assign mem_address  = (state_q == IDLE) ? cpu_address[31:4] : {miss_tag_q, miss_index_q};
  assign cpu_busywait = cpu_read && ((state_q != IDLE) || !hit);
  assign cpu_readdata = hit_ok ? hit_word : readdata_q;

endmodule
